// File: rtl/seg7_scan_decoder_if.sv
// seg7_scan_decoder_if: scanned display bus in, decoded HH:MM frame out
interface seg7_scan_decoder_if;
  logic [6:0] seg_in;
  logic       dp_in;
  logic [3:0] sel_in;
  logic       invert_seg;
  logic       invert_sel;
  logic [3:0] min_u, min_d, hrs_u, hrs_d;
  logic [3:0] dp_out;
  logic       frame_valid;
  logic       range_err;
  logic       seg_err;
  logic       sel_err;
  logic       stalled;
  modport master (
    output seg_in, dp_in, sel_in, invert_seg, invert_sel,
    input  min_u, min_d, hrs_u, hrs_d, dp_out, frame_valid, range_err, seg_err, sel_err, stalled
  );
  modport slave (
    input  seg_in, dp_in, sel_in, invert_seg, invert_sel,
    output min_u, min_d, hrs_u, hrs_d, dp_out, frame_valid, range_err, seg_err, sel_err, stalled
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: decodes a scanned 7-seg HH:MM display back to BCD frames; SEG7_DEC_CONFIRM_EN publishes only twice-matching frames
module seg7_scan_decoder #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 16
) (
  input logic clk,
  input logic reset,
  seg7_scan_decoder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO      = CNT_W'(TIMEOUT_CYCLES);
  state_t           state;
  logic [6:0]       seg_r;
  logic             dp_r;
  logic [3:0]       sel_r, sel_p;
  logic [CNT_W-1:0] cnt, stall_cnt;
  logic [3:0]       hold [4];
  logic [3:0]       hold_dp, seen;
  logic             full;
  logic [3:0]       dig;
  logic [1:0]       idx;
  logic             hot, chg, cap, bad, pub;
`ifdef SEG7_DEC_CONFIRM_EN
  logic [19:0]      frame, cand;
  logic             cand_ok;
`endif
  function automatic logic [3:0] decode(input logic [6:0] s);
    case (s)
      7'h3F:   return 4'h0;
      7'h06:   return 4'h1;
      7'h5B:   return 4'h2;
      7'h4F:   return 4'h3;
      7'h66:   return 4'h4;
      7'h6D:   return 4'h5;
      7'h7C:   return 4'h6;
      7'h07:   return 4'h7;
      7'h7F:   return 4'h8;
      7'h67:   return 4'h9;
      7'h00:   return 4'hF;
      default: return 4'hE;
    endcase
  endfunction
  always_comb begin
    dig = decode(seg_r);
    idx = sel_r[3] ? 2'd3 : sel_r[2] ? 2'd2 : sel_r[1] ? 2'd1 : 2'd0;
    hot = $onehot(sel_r);
    chg = sel_r != sel_p;
    cap = state == SETTLE && !chg && cnt >= SET_LAST;
    bad = hold[0] > 4'd9 || hold[1] > 4'd5 || hold[2] > 4'd9 || hold[3] > 4'd2 ||
          (hold[3] == 4'd2 && hold[2] > 4'd3);
`ifdef SEG7_DEC_CONFIRM_EN
    frame = {hold[3], hold[2], hold[1], hold[0], hold_dp};
    pub   = full && cand_ok && cand == frame;
`else
    pub   = full;
`endif
  end
  always_ff @(posedge clk)
    if (reset) begin
      seg_r <= '0;
      dp_r  <= 1'b0;
      sel_r <= '0;
      sel_p <= '0;
    end else begin
      seg_r <= bus.invert_seg ? ~bus.seg_in : bus.seg_in;
      dp_r  <= bus.dp_in ^ bus.invert_seg;
      sel_r <= bus.invert_sel ? ~bus.sel_in : bus.sel_in;
      sel_p <= sel_r;
    end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (state != IDLE && chg) begin
      state <= hot ? SETTLE : IDLE;
      cnt   <= hot ? CNT_W'(1) : '0;
    end else if (state == IDLE && hot) begin
      state <= SETTLE;
      cnt   <= CNT_W'(1);
    end else if (cap)
      state <= HELD;
    else if (state == SETTLE)
      cnt <= cnt + 1'b1;
  always_ff @(posedge clk)
    if (reset) begin
      stall_cnt   <= '0;
      bus.sel_err <= 1'b0;
    end else begin
      stall_cnt   <= chg ? '0 : stall_cnt == TMO ? stall_cnt : stall_cnt + 1'b1;
      bus.sel_err <= chg && !hot && sel_r != 4'd0;
    end
  assign bus.stalled = stall_cnt == TMO;
  always_ff @(posedge clk)
    if (reset) begin
      hold            <= '{default: 4'hF};
      hold_dp         <= '0;
      seen            <= '0;
      full            <= 1'b0;
      bus.seg_err     <= 1'b0;
      bus.frame_valid <= 1'b0;
      bus.range_err   <= 1'b0;
      bus.min_u       <= 4'hF;
      bus.min_d       <= 4'hF;
      bus.hrs_u       <= 4'hF;
      bus.hrs_d       <= 4'hF;
      bus.dp_out      <= '0;
    end else begin
      bus.seg_err     <= cap && dig == 4'hE;
      full            <= cap && (seen | (4'b1 << idx)) == 4'hF;
      bus.frame_valid <= pub;
      if (cap) begin
        hold[idx]    <= dig;
        hold_dp[idx] <= dp_r;
        seen         <= seen | (4'b1 << idx);
      end
      if (full) seen <= '0;
      if (pub) begin
        bus.min_u     <= hold[0];
        bus.min_d     <= hold[1];
        bus.hrs_u     <= hold[2];
        bus.hrs_d     <= hold[3];
        bus.dp_out    <= hold_dp;
        bus.range_err <= bad;
      end
    end
`ifdef SEG7_DEC_CONFIRM_EN
  always_ff @(posedge clk)
    if (reset) begin
      cand    <= '0;
      cand_ok <= 1'b0;
    end else if (full) begin
      cand    <= frame;
      cand_ok <= 1'b1;
    end
`endif
endmodule
